e300_reset_sequencer: RTL and testbench

Reset controller for the Freedom E300 SoC on DE10-Nano. It gathers PLL lock, the KEY[0] pushbutton and the debug module's `io_ndreset` request. From these it sequences the three SoC reset domains: JTAG/debug, always-on (`aon_erst_n`) and peripheral. It replaces ad-hoc reset gating in the top level, runs in the 32 MHz SoC clock domain, and reports the current state and the last reset cause for LED display.

---
 rtl/e300_rst_pkg.sv | 28 ++
 rtl/e300_input_cond.sv | 73 +++++++
 rtl/e300_reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_e300_reset_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/e300_rst_pkg.sv
// Shared types for the E300 reset sequencer: state encodings, reset-cause codes
// and the counter-width helper used by the sequencer and its input conditioners.
package e300_rst_pkg;

    typedef enum logic [2:0] {
        ST_POR_HOLD     = 3'd0,
        ST_WAIT_LOCK    = 3'd1,
        ST_LOCK_STABLE  = 3'd2,
        ST_RELEASE_AON  = 3'd3,
        ST_RUN          = 3'd4,
        ST_NDRESET_HOLD = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_LOCK_LOSS = 2'd1,
        CAUSE_KEY       = 2'd2,
        CAUSE_NDRESET   = 2'd3
    } cause_e;

    // Width able to hold (max(a, b) - 1), never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/e300_input_cond.sv
// Brings one asynchronous level into the clock domain through a SYNC_STAGES
// flop chain, optionally inverts it, and optionally debounces the result.
module e300_input_cond
    import e300_rst_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter bit DEBOUNCE_EN  = 1'b0,
    parameter int DEBOUNCE_CYC = 65536,
    parameter bit INVERT       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din_a,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   cond_s;

    always_comb begin
        sync_d = SYNC_STAGES'({sync_q, din_a});
    end

    // NOTE: synchronizer flops are reset to a known value so the sequencer
    // never sees X after power-on; this is cheap because the chain is tiny.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign cond_s = sync_q[SYNC_STAGES-1] ^ INVERT;

    if (DEBOUNCE_EN) begin : g_debounce
        localparam int              DB_W    = cnt_width(DEBOUNCE_CYC, 1);
        localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
        localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

        logic            stable_q, stable_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;

        // Any cycle agreeing with the current level restarts the window.
        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (cond_s != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = cond_s;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                stable_q <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                stable_q <= stable_d;
                db_cnt_q <= db_cnt_d;
            end
        end

        assign dout = stable_q;
    end else begin : g_direct
        assign dout = cond_s;
    end

endmodule

// File: rtl/e300_reset_sequencer.sv
// Freedom E300 reset sequencer: orders JTAG, always-on and peripheral resets from
// PLL lock, KEY[0] and ndreset. Define E300_KEY_DEBOUNCE_EN to debounce KEY[0].
module e300_reset_sequencer
    import e300_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYC        = 64,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int DEBOUNCE_CYC    = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked_a,
    input  logic       key_n_a,
    input  logic       ndreset_req,
    output logic       jtag_reset,
    output logic       aon_erst_n,
    output logic       periph_reset,
    output logic [2:0] state_o,
    output logic [1:0] reset_cause
);

    localparam int               CNT_W       = cnt_width(HOLD_CYC, LOCK_STABLE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef E300_KEY_DEBOUNCE_EN
    localparam bit KEY_DEBOUNCE = 1'b1;
`else
    localparam bit KEY_DEBOUNCE = 1'b0;
`endif

    logic locked_s;
    logic key_pressed;

    e300_input_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_EN (1'b0),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .INVERT      (1'b0)
    ) u_lock_cond (
        .clock(clock),
        .reset(reset),
        .din_a(pll_locked_a),
        .dout (locked_s)
    );

    e300_input_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_EN (KEY_DEBOUNCE),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .INVERT      (1'b1)
    ) u_key_cond (
        .clock(clock),
        .reset(reset),
        .din_a(key_n_a),
        .dout (key_pressed)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_e           cause_q, cause_d;
    logic             jtag_q, jtag_d;
    logic             aon_n_q, aon_n_d;
    logic             periph_q, periph_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        case (state_q)
            ST_POR_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s && !key_pressed) begin
                    state_d = ST_LOCK_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_LOCK_STABLE: begin
                if (!locked_s || key_pressed) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE_AON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE_AON: begin
                if (!locked_s || key_pressed) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK_LOSS;
                end else if (key_pressed) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_KEY;
                end else if (ndreset_req) begin
                    state_d = ST_NDRESET_HOLD;
                    cause_d = CAUSE_NDRESET;
                end
            end
            ST_NDRESET_HOLD: begin
                // Counter parks at its last value while the debugger keeps asking.
                if (cnt_q == HOLD_LAST) begin
                    if (!ndreset_req) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_POR_HOLD;
                cnt_d   = '0;
            end
        endcase

        // POR_HOLD is reachable only through reset, so jtag_reset can only fall.
        jtag_d   = jtag_q && (state_d == ST_POR_HOLD);
        aon_n_d  = (state_d == ST_RELEASE_AON) || (state_d == ST_RUN);
        periph_d = (state_d != ST_RUN);
    end

    // NOTE: non-blocking assignments keep all flops updating from the values
    // present before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_POR_HOLD;
            cnt_q    <= '0;
            cause_q  <= CAUSE_POR;
            jtag_q   <= 1'b1;
            aon_n_q  <= 1'b0;
            periph_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            jtag_q   <= jtag_d;
            aon_n_q  <= aon_n_d;
            periph_q <= periph_d;
        end
    end

    assign jtag_reset   = jtag_q;
    assign aon_erst_n   = aon_n_q;
    assign periph_reset = periph_q;
    assign state_o      = state_q;
    assign reset_cause  = cause_q;

endmodule

// File: tb/tb_e300_reset_sequencer.sv
// Directed bench for e300_reset_sequencer: expected output snapshots are queued
// per absolute cycle as stimulus is planned and compared when that cycle arrives.
module tb_e300_reset_sequencer;
    import e300_rst_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked_a;
    logic       key_n_a;
    logic       ndreset_req;
    logic       jtag_reset;
    logic       aon_erst_n;
    logic       periph_reset;
    logic [2:0] state_o;
    logic [1:0] reset_cause;

    e300_reset_sequencer #(
        .SYNC_STAGES    (2),
        .HOLD_CYC       (4),
        .LOCK_STABLE_CYC(8),
        .DEBOUNCE_CYC   (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked_a(pll_locked_a),
        .key_n_a     (key_n_a),
        .ndreset_req (ndreset_req),
        .jtag_reset  (jtag_reset),
        .aon_erst_n  (aon_erst_n),
        .periph_reset(periph_reset),
        .state_o     (state_o),
        .reset_cause (reset_cause)
    );

    always #5 clock = ~clock;

    // Absolute edge count: after posedge n, ncyc == n.
    int ncyc = 0;
    always @(posedge clock) ncyc <= ncyc + 1;

    typedef struct {
        int         cyc;
        logic       j;
        logic       a;
        logic       p;
        logic [2:0] st;
        logic [1:0] c;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    total = 0;
    int    bad   = 0;
    exp_t  mon_e;
    string mon_tag;

    task automatic check(input string tag, input string what,
                         input logic [31:0] got, input logic [31:0] expd);
        total++;
        assert (got === expd) else begin
            bad++;
            $error("FAIL %s.%s cyc=%0d observed=%0d expected=%0d", tag, what, ncyc, got, expd);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic j, input logic a,
                             input logic p, input state_e st, input cause_e cs);
        exp_t e;
        int   i;
        e.cyc = c;
        e.j   = j;
        e.a   = a;
        e.p   = p;
        e.st  = st;
        e.c   = cs;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
        sb_tag.insert(i, tag);
    endtask

    task automatic step_to(input int c);
        while (ncyc < c) @(negedge clock);
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
            mon_e   = sb.pop_front();
            mon_tag = sb_tag.pop_front();
            check(mon_tag, "cycle", ncyc, mon_e.cyc);
            check(mon_tag, "jtag_reset", 32'(jtag_reset), 32'(mon_e.j));
            check(mon_tag, "aon_erst_n", 32'(aon_erst_n), 32'(mon_e.a));
            check(mon_tag, "periph_reset", 32'(periph_reset), 32'(mon_e.p));
            check(mon_tag, "state_o", 32'(state_o), 32'(mon_e.st));
            check(mon_tag, "reset_cause", 32'(reset_cause), 32'(mon_e.c));
        end
    end

    initial begin
        int base, t, u, e, v, w, y, base2, z, base3;
`ifdef E300_KEY_DEBOUNCE_EN
        int x;
`endif
        reset        = 1'b1;
        pll_locked_a = 1'b1;
        key_n_a      = 1'b1;
        ndreset_req  = 1'b0;

        // Reset state while reset is held.
        expect_at(2, "por_reset", 1, 0, 1, ST_POR_HOLD, CAUSE_POR);

        // 1: power-on sequence with lock high throughout.
        step_to(3);
        base = ncyc;
        reset = 1'b0;
        expect_at(base + 3,  "t1_por_last",   1, 0, 1, ST_POR_HOLD,    CAUSE_POR);
        expect_at(base + 4,  "t1_jtag_fall",  0, 0, 1, ST_WAIT_LOCK,   CAUSE_POR);
        expect_at(base + 5,  "t1_stable",     0, 0, 1, ST_LOCK_STABLE, CAUSE_POR);
        expect_at(base + 12, "t1_aon_low",    0, 0, 1, ST_LOCK_STABLE, CAUSE_POR);
        expect_at(base + 13, "t1_aon_rise",   0, 1, 1, ST_RELEASE_AON, CAUSE_POR);
        expect_at(base + 16, "t1_periph_hi",  0, 1, 1, ST_RELEASE_AON, CAUSE_POR);
        expect_at(base + 17, "t1_run",        0, 1, 0, ST_RUN,         CAUSE_POR);

        // 3: lock loss in RUN, then relock; 2: 1-cycle glitch at LOCK_STABLE count 5.
        t = base + 19;
        expect_at(t + 2,  "t3_run_still",  0, 1, 0, ST_RUN,         CAUSE_POR);
        expect_at(t + 3,  "t3_lock_loss",  0, 0, 1, ST_WAIT_LOCK,   CAUSE_LOCK_LOSS);
        expect_at(t + 7,  "t3_wait",       0, 0, 1, ST_WAIT_LOCK,   CAUSE_LOCK_LOSS);
        expect_at(t + 8,  "t3_restart",    0, 0, 1, ST_LOCK_STABLE, CAUSE_LOCK_LOSS);
        expect_at(t + 13, "t2_cnt5",       0, 0, 1, ST_LOCK_STABLE, CAUSE_LOCK_LOSS);
        expect_at(t + 14, "t2_glitch",     0, 0, 1, ST_WAIT_LOCK,   CAUSE_LOCK_LOSS);
        expect_at(t + 15, "t2_relock",     0, 0, 1, ST_LOCK_STABLE, CAUSE_LOCK_LOSS);
        expect_at(t + 22, "t2_full8_low",  0, 0, 1, ST_LOCK_STABLE, CAUSE_LOCK_LOSS);
        expect_at(t + 23, "t2_full8_rel",  0, 1, 1, ST_RELEASE_AON, CAUSE_LOCK_LOSS);
        expect_at(t + 26, "t2_rel_last",   0, 1, 1, ST_RELEASE_AON, CAUSE_LOCK_LOSS);
        expect_at(t + 27, "t2_run",        0, 1, 0, ST_RUN,         CAUSE_LOCK_LOSS);
        step_to(t);      pll_locked_a = 1'b0;
        step_to(t + 5);  pll_locked_a = 1'b1;
        step_to(t + 11); pll_locked_a = 1'b0;
        step_to(t + 12); pll_locked_a = 1'b1;

        // 4: ndreset pulse, then ndreset held for 10 cycles.
        u = t + 29;
        e = u + 1;
        v = e + 19;
        expect_at(u,      "t4_run",        0, 1, 0, ST_RUN,          CAUSE_LOCK_LOSS);
        expect_at(e,      "t4_nd_enter",   0, 0, 1, ST_NDRESET_HOLD, CAUSE_NDRESET);
        expect_at(e + 3,  "t4_nd_last",    0, 0, 1, ST_NDRESET_HOLD, CAUSE_NDRESET);
        expect_at(e + 4,  "t4_nd_exit",    0, 0, 1, ST_WAIT_LOCK,    CAUSE_NDRESET);
        expect_at(e + 5,  "t4_stable",     0, 0, 1, ST_LOCK_STABLE,  CAUSE_NDRESET);
        expect_at(e + 17, "t4_run_again",  0, 1, 0, ST_RUN,          CAUSE_NDRESET);
        expect_at(v + 1,  "t4h_enter",     0, 0, 1, ST_NDRESET_HOLD, CAUSE_NDRESET);
        expect_at(v + 10, "t4h_held",      0, 0, 1, ST_NDRESET_HOLD, CAUSE_NDRESET);
        expect_at(v + 11, "t4h_exit",      0, 0, 1, ST_WAIT_LOCK,    CAUSE_NDRESET);
        expect_at(v + 12, "t4h_stable",    0, 0, 1, ST_LOCK_STABLE,  CAUSE_NDRESET);
        expect_at(v + 24, "t4h_run",       0, 1, 0, ST_RUN,          CAUSE_NDRESET);
        step_to(u);      ndreset_req = 1'b1;
        step_to(u + 1);  ndreset_req = 1'b0;
        step_to(v);      ndreset_req = 1'b1;
        step_to(v + 10); ndreset_req = 1'b0;

        // 5: key press handling.
        w = v + 26;
`ifdef E300_KEY_DEBOUNCE_EN
        x = w + 20;
        y = x + 53;
        expect_at(w + 6,  "t5_bounce_a",   0, 1, 0, ST_RUN,         CAUSE_NDRESET);
        expect_at(w + 14, "t5_bounce_b",   0, 1, 0, ST_RUN,         CAUSE_NDRESET);
        expect_at(x + 18, "t5_db_pending", 0, 1, 0, ST_RUN,         CAUSE_NDRESET);
        expect_at(x + 19, "t5_key_reset",  0, 0, 1, ST_WAIT_LOCK,   CAUSE_KEY);
        expect_at(x + 38, "t5_rel_pend",   0, 0, 1, ST_WAIT_LOCK,   CAUSE_KEY);
        expect_at(x + 39, "t5_rel_done",   0, 0, 1, ST_LOCK_STABLE, CAUSE_KEY);
        expect_at(x + 51, "t5_run",        0, 1, 0, ST_RUN,         CAUSE_KEY);
        step_to(w);      key_n_a = 1'b0;
        step_to(w + 10); key_n_a = 1'b1;
        step_to(x);      key_n_a = 1'b0;
        step_to(x + 20); key_n_a = 1'b1;
`else
        y = w + 20;
        expect_at(w + 2,  "t5_run_still",  0, 1, 0, ST_RUN,         CAUSE_NDRESET);
        expect_at(w + 3,  "t5_key_reset",  0, 0, 1, ST_WAIT_LOCK,   CAUSE_KEY);
        expect_at(w + 5,  "t5_key_held",   0, 0, 1, ST_WAIT_LOCK,   CAUSE_KEY);
        expect_at(w + 6,  "t5_released",   0, 0, 1, ST_LOCK_STABLE, CAUSE_KEY);
        expect_at(w + 18, "t5_run",        0, 1, 0, ST_RUN,         CAUSE_KEY);
        step_to(w);      key_n_a = 1'b0;
        step_to(w + 3);  key_n_a = 1'b1;
`endif

        // 6: reset asserted in RUN and in NDRESET_HOLD.
        base2 = y + 2;
        z     = base2 + 18;
        base3 = z + 5;
        expect_at(y + 1,      "t6_run_rst",   1, 0, 1, ST_POR_HOLD,     CAUSE_POR);
        expect_at(y + 2,      "t6_rst_hold",  1, 0, 1, ST_POR_HOLD,     CAUSE_POR);
        expect_at(base2 + 4,  "t6_wait",      0, 0, 1, ST_WAIT_LOCK,    CAUSE_POR);
        expect_at(base2 + 17, "t6_run",       0, 1, 0, ST_RUN,          CAUSE_POR);
        expect_at(z + 1,      "t6_nd_enter",  0, 0, 1, ST_NDRESET_HOLD, CAUSE_NDRESET);
        expect_at(z + 3,      "t6_nd_mid",    0, 0, 1, ST_NDRESET_HOLD, CAUSE_NDRESET);
        expect_at(z + 4,      "t6_nd_rst",    1, 0, 1, ST_POR_HOLD,     CAUSE_POR);
        expect_at(base3 + 4,  "t6_recover",   0, 0, 1, ST_WAIT_LOCK,    CAUSE_POR);
        expect_at(base3 + 5,  "t6_stable",    0, 0, 1, ST_LOCK_STABLE,  CAUSE_POR);
        step_to(y);      reset = 1'b1;
        step_to(y + 2);  reset = 1'b0;
        step_to(z);      ndreset_req = 1'b1;
        step_to(z + 3);  reset = 1'b1;
        step_to(z + 4);  ndreset_req = 1'b0;
        step_to(z + 5);  reset = 1'b0;

        step_to(base3 + 7);
        repeat (20) if (sb.size() != 0) @(negedge clock);
        check("drain", "pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
